// File: rtl/sa_pkg.sv
// ----------------------------------------------------------------------------
// sa_pkg
// Shared constants and types for the mesh-router switch allocator.
//   - Port-index constants for a 2D mesh router (LOCAL, X+, X-, Y+, Y-).
//   - lock_t: per-output wormhole lock record (valid + owning input index).
//   - sel_stop(): crossbar select encoding that means "no source".
// ----------------------------------------------------------------------------
package sa_pkg;

    localparam int PORT_LOCAL = 0;
    localparam int PORT_XP    = 1;
    localparam int PORT_XM    = 2;
    localparam int PORT_YP    = 3;
    localparam int PORT_YM    = 4;

    // Wide enough for any practical router radix; the allocator only
    // ever stores indices below NUM_PORTS here.
    localparam int LOCK_IDX_W = 8;

    typedef struct packed {
        logic                  valid;
        logic [LOCK_IDX_W-1:0] idx;
    } lock_t;

    // The select value one past the last input index means "idle":
    // the crossbar drives nothing onto that output.
    function automatic int sel_stop(input int num_ports);
        return num_ports;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational N-way round-robin pick: returns the first requester found
// searching circularly upward from ptr. The pointer itself lives in the
// parent so that lock and pointer updates stay together there.
// Ports:
//   req   in  N   request vector, one bit per input
//   ptr   in  PW  highest-priority index this cycle (must be < N)
//   found out 1   at least one request present
//   idx   out PW  index of the winning request (0 when found=0)
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 5,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          found,
    output logic [PW-1:0] idx
);

    int cand;

    // Circular first-one search starting at ptr.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end else begin
                cand = cand;
            end
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = PW'(cand);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/switch_allocator_rr.sv
// ----------------------------------------------------------------------------
// switch_allocator_rr
// Wormhole switch allocator for one mesh router. Each output port runs an
// independent round-robin arbiter over the inputs whose head flit targets it.
// Once an output carries a non-tail flit it stays locked to that input until
// the tail crosses. Grants are combinational: a flit granted in a cycle is
// popped from its input buffer in that same cycle.
//
// Optional feature (macro SA_STARVE_GUARD_EN): per-input saturating wait
// counters; an input that has waited MAX_WAIT cycles wins the next unlocked
// arbitration on its output ahead of round-robin (lowest index among several).
//
// Ports:
//   clk        in   1                clock
//   rst        in   1                synchronous reset, active-high
//   in_valid   in   NUM_PORTS        input i has a flit at its buffer head
//   in_dst     in   NUM_PORTS*DST_W  destination output of input i (slice i)
//   in_tail    in   NUM_PORTS        head flit of input i is a tail
//   out_ready  in   NUM_PORTS        downstream of output o accepts a flit
//   in_grant   out  NUM_PORTS        pop input i this cycle
//   out_sel    out  NUM_PORTS*SEL_W  crossbar source for output o, or SEL_STOP
//   out_valid  out  NUM_PORTS        output o carries a flit this cycle
// ----------------------------------------------------------------------------
module switch_allocator_rr #(
    parameter int NUM_PORTS = 5,
    parameter int DST_W     = $clog2(NUM_PORTS),
    parameter int SEL_W     = $clog2(NUM_PORTS + 1),
    parameter int MAX_WAIT  = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_PORTS-1:0]       in_valid,
    input  logic [NUM_PORTS*DST_W-1:0] in_dst,
    input  logic [NUM_PORTS-1:0]       in_tail,
    input  logic [NUM_PORTS-1:0]       out_ready,
    output logic [NUM_PORTS-1:0]       in_grant,
    output logic [NUM_PORTS*SEL_W-1:0] out_sel,
    output logic [NUM_PORTS-1:0]       out_valid
);

    import sa_pkg::*;

    localparam logic [SEL_W-1:0] SEL_STOP_C = SEL_W'(sel_stop(NUM_PORTS));
    localparam logic [DST_W-1:0] LAST_IDX_C = DST_W'(NUM_PORTS - 1);

    logic [NUM_PORTS-1:0] req_s [NUM_PORTS];
    logic [NUM_PORTS-1:0] arb_found_s;
    logic [DST_W-1:0]     arb_idx_s [NUM_PORTS];
    logic [NUM_PORTS-1:0] xfer_s;
    logic [DST_W-1:0]     win_s [NUM_PORTS];
    logic [NUM_PORTS-1:0] starved_s;

    logic [DST_W-1:0]     ptr_r  [NUM_PORTS];
    lock_t                lock_r [NUM_PORTS];

    // Request matrix: an out-of-range destination matches no output.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                req_s[o][i] = in_valid[i] && (in_dst[i*DST_W +: DST_W] == DST_W'(o));
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_PORTS; g++) begin : g_arb
            rr_arbiter #(
                .N  (NUM_PORTS),
                .PW (DST_W)
            ) u_rr_arbiter (
                .req   (req_s[g]),
                .ptr   (ptr_r[g]),
                .found (arb_found_s[g]),
                .idx   (arb_idx_s[g])
            );
        end
    endgenerate

`ifdef SA_STARVE_GUARD_EN
    localparam int               WAIT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX_C = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_r [NUM_PORTS];

    // An input is starved once its wait counter has saturated.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            starved_s[i] = (wait_r[i] == WAIT_MAX_C);
        end
    end

    // Saturating wait counters: count while waiting, clear on grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                wait_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (in_grant[i]) begin
                    wait_r[i] <= '0;
                end else if (in_valid[i] && (wait_r[i] != WAIT_MAX_C)) begin
                    wait_r[i] <= wait_r[i] + WAIT_W'(1);
                end else begin
                    wait_r[i] <= wait_r[i];
                end
            end
        end
    end
`else
    // Pure round-robin build: nobody is ever starved.
    assign starved_s = '0;
`endif

    logic             starve_hit_s;
    logic [DST_W-1:0] starve_idx_s;
    logic [DST_W-1:0] lock_idx_s;

    // Per-output winner selection: lock owner, then starved input, then RR.
    always_comb begin
        starve_hit_s = 1'b0;
        starve_idx_s = '0;
        lock_idx_s   = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            xfer_s[o]    = 1'b0;
            win_s[o]     = '0;
            starve_hit_s = 1'b0;
            starve_idx_s = '0;
            // Descending scan so the lowest starved index is left standing.
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (req_s[o][i] && starved_s[i]) begin
                    starve_hit_s = 1'b1;
                    starve_idx_s = DST_W'(i);
                end else begin
                    starve_hit_s = starve_hit_s;
                end
            end
            lock_idx_s = DST_W'(lock_r[o].idx);
            if (lock_r[o].valid) begin
                // Locked: only the owner may move, otherwise the output idles.
                win_s[o]  = lock_idx_s;
                xfer_s[o] = req_s[o][lock_idx_s] && out_ready[o];
            end else if (starve_hit_s) begin
                win_s[o]  = starve_idx_s;
                xfer_s[o] = out_ready[o];
            end else begin
                win_s[o]  = arb_idx_s[o];
                xfer_s[o] = arb_found_s[o] && out_ready[o];
            end
        end
    end

    // Drive grants and crossbar selects; reset forces the idle pattern.
    always_comb begin
        in_grant  = '0;
        out_valid = '0;
        out_sel   = {NUM_PORTS{SEL_STOP_C}};
        if (rst) begin
            in_grant = '0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (xfer_s[o]) begin
                    in_grant[win_s[o]]           = 1'b1;
                    out_valid[o]                 = 1'b1;
                    out_sel[o*SEL_W +: SEL_W]    = SEL_W'(win_s[o]);
                end else begin
                    out_valid[o] = 1'b0;
                end
            end
        end
    end

    // Lock and pointer update: non-tail takes the lock, tail releases it
    // and moves priority past the winner. A stalled winner keeps priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                ptr_r[o]  <= '0;
                lock_r[o] <= '0;
            end
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (xfer_s[o]) begin
                    if (in_tail[win_s[o]]) begin
                        lock_r[o] <= '0;
                        ptr_r[o]  <= (win_s[o] == LAST_IDX_C) ? '0 : (win_s[o] + DST_W'(1));
                    end else begin
                        lock_r[o].valid <= 1'b1;
                        lock_r[o].idx   <= LOCK_IDX_W'(win_s[o]);
                    end
                end else begin
                    lock_r[o] <= lock_r[o];
                    ptr_r[o]  <= ptr_r[o];
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator_rr.sv
// ----------------------------------------------------------------------------
// tb_switch_allocator_rr
// Scoreboard bench: the driver applies one input vector per cycle, computes
// the expected outputs from a packet-level reference model (lock owner,
// priority pointer and wait count per port, kept as plain integers) and
// queues them; a monitor pops and compares on every falling edge. Directed
// sequences additionally check hand-derived grant patterns.
// ----------------------------------------------------------------------------
module tb_switch_allocator_rr;

    localparam int N  = 5;
    localparam int DW = $clog2(N);
    localparam int SW = $clog2(N + 1);
`ifdef SA_STARVE_GUARD_EN
    localparam int MW    = 3;
    localparam bit GUARD = 1'b1;
`else
    localparam int MW    = 15;
    localparam bit GUARD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      in_valid;
    logic [N*DW-1:0]   in_dst;
    logic [N-1:0]      in_tail;
    logic [N-1:0]      out_ready;
    logic [N-1:0]      in_grant;
    logic [N*SW-1:0]   out_sel;
    logic [N-1:0]      out_valid;

    always #5 clk = ~clk;

    switch_allocator_rr #(
        .NUM_PORTS (N),
        .MAX_WAIT  (MW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_dst    (in_dst),
        .in_tail   (in_tail),
        .out_ready (out_ready),
        .in_grant  (in_grant),
        .out_sel   (out_sel),
        .out_valid (out_valid)
    );

    typedef struct packed {
        logic [N-1:0]    grant;
        logic [N-1:0]    valid;
        logic [N*SW-1:0] sel;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: lock owner (-1 = free), priority input, wait cycles.
    int m_lock [N];
    int m_ptr  [N];
    int m_wait [N];

    function automatic bit wants(input int i, input int o);
        logic [DW-1:0] d;
        d = in_dst[i*DW +: DW];
        return in_valid[i] && (int'(d) == o);
    endfunction

    function automatic exp_t model_step(input bit rs);
        exp_t e;
        int   win [N];
        int   cand;
        int   c;
        e.grant = '0;
        e.valid = '0;
        for (int o = 0; o < N; o++) e.sel[o*SW +: SW] = SW'(N);
        if (rs) begin
            for (int k = 0; k < N; k++) begin
                m_lock[k] = -1;
                m_ptr[k]  = 0;
                m_wait[k] = 0;
            end
            return e;
        end
        for (int o = 0; o < N; o++) begin
            win[o] = -1;
            if (m_lock[o] >= 0) begin
                if (wants(m_lock[o], o) && out_ready[o]) win[o] = m_lock[o];
            end else begin
                cand = -1;
                if (GUARD) begin
                    for (int i = 0; i < N; i++)
                        if (cand < 0 && wants(i, o) && m_wait[i] == MW) cand = i;
                end
                for (int j = 0; j < N; j++) begin
                    c = (m_ptr[o] + j) % N;
                    if (cand < 0 && wants(c, o)) cand = c;
                end
                if (cand >= 0 && out_ready[o]) win[o] = cand;
            end
            if (win[o] >= 0) begin
                e.grant[win[o]]    = 1'b1;
                e.valid[o]         = 1'b1;
                e.sel[o*SW +: SW]  = SW'(win[o]);
            end
        end
        for (int o = 0; o < N; o++) begin
            if (win[o] >= 0) begin
                if (in_tail[win[o]]) begin
                    m_lock[o] = -1;
                    m_ptr[o]  = (win[o] + 1) % N;
                end else begin
                    m_lock[o] = win[o];
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (e.grant[i]) m_wait[i] = 0;
            else if (in_valid[i] && m_wait[i] < MW) m_wait[i] = m_wait[i] + 1;
        end
        return e;
    endfunction

    function automatic logic [N*DW-1:0] dsts(input int a, input int b, input int c,
                                             input int d, input int f);
        logic [N*DW-1:0] r;
        r[0*DW +: DW] = DW'(a);
        r[1*DW +: DW] = DW'(b);
        r[2*DW +: DW] = DW'(c);
        r[3*DW +: DW] = DW'(d);
        r[4*DW +: DW] = DW'(f);
        return r;
    endfunction

    task automatic step(input bit rs, input logic [N-1:0] v, input logic [N*DW-1:0] d,
                        input logic [N-1:0] t, input logic [N-1:0] r);
        @(posedge clk);
        #1;
        rst       = rs;
        in_valid  = v;
        in_dst    = d;
        in_tail   = t;
        out_ready = r;
        sb_q.push_back(model_step(rs));
    endtask

    task automatic expect_grant(input string name, input logic [N-1:0] g);
        @(negedge clk);
        #1;
        checks++;
        if (in_grant !== g) begin
            errors++;
            $display("FAIL %s: in_grant=%b expected=%b", name, in_grant, g);
        end
    endtask

    // Monitor: compare every presented output cycle against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (in_grant !== e.grant || out_valid !== e.valid || out_sel !== e.sel) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t: grant=%b/%b valid=%b/%b sel=%h/%h (actual/expected)",
                             $time, in_grant, e.grant, out_valid, e.valid, out_sel, e.sel);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*DW-1:0] rd;
        logic [N-1:0]    rr;
        rst = 1'b1; in_valid = '0; in_dst = '0; in_tail = '0; out_ready = '0;

        // Reset held with random inputs: idle outputs.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, N'($urandom), N*DW'($urandom), N'($urandom), N'($urandom));
            expect_grant("reset_grant", 5'b00000);
            checks++;
            if (out_valid !== 5'b00000 || out_sel !== {N{3'd5}}) begin
                errors++;
                $display("FAIL reset_outputs: valid=%b sel=%h expected valid=0 sel=all 5", out_valid, out_sel);
            end
        end

        // Contention on output 3 from inputs 1,2,4, all single-flit packets.
        step(1'b0, 5'b10110, dsts(3,3,3,3,3), 5'b11111, 5'b11111); expect_grant("contend1", 5'b00010);
        step(1'b0, 5'b10110, dsts(3,3,3,3,3), 5'b11111, 5'b11111); expect_grant("contend2", 5'b00100);
        step(1'b0, 5'b10110, dsts(3,3,3,3,3), 5'b11111, 5'b11111); expect_grant("contend3", 5'b10000);
        step(1'b0, 5'b10110, dsts(3,3,3,3,3), 5'b11111, 5'b11111); expect_grant("contend4", 5'b00010);

        // Wormhole: input 0 holds output 2 through its tail; input 3 waits.
        step(1'b0, 5'b01001, dsts(2,0,0,2,0), 5'b01000, 5'b11111); expect_grant("worm_head", 5'b00001);
        step(1'b0, 5'b01001, dsts(2,0,0,2,0), 5'b01000, 5'b11111); expect_grant("worm_body1", 5'b00001);
        step(1'b0, 5'b01001, dsts(2,0,0,2,0), 5'b01000, 5'b11111); expect_grant("worm_body2", 5'b00001);
        step(1'b0, 5'b01001, dsts(2,0,0,2,0), 5'b01001, 5'b11111); expect_grant("worm_tail", 5'b00001);
        step(1'b0, 5'b01000, dsts(2,0,0,2,0), 5'b01000, 5'b11111); expect_grant("worm_next", 5'b01000);

        // Backpressure on output 1.
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 5'b00100, dsts(0,0,1,0,0), 5'b11111, 5'b11101);
            expect_grant("backpressure", 5'b00000);
        end
        step(1'b0, 5'b00100, dsts(0,0,1,0,0), 5'b11111, 5'b11111); expect_grant("bp_release", 5'b00100);

        // Lock bubble on output 4.
        step(1'b0, 5'b00011, dsts(4,4,0,0,0), 5'b00010, 5'b11111); expect_grant("bubble_head", 5'b00001);
        step(1'b0, 5'b00010, dsts(4,4,0,0,0), 5'b00010, 5'b11111); expect_grant("bubble_idle1", 5'b00000);
        step(1'b0, 5'b00010, dsts(4,4,0,0,0), 5'b00010, 5'b11111); expect_grant("bubble_idle2", 5'b00000);
        step(1'b0, 5'b00011, dsts(4,4,0,0,0), 5'b00011, 5'b11111); expect_grant("bubble_tail", 5'b00001);
        step(1'b0, 5'b00010, dsts(4,4,0,0,0), 5'b00010, 5'b11111); expect_grant("bubble_next", 5'b00010);

        // Out-of-range destinations request nothing.
        step(1'b0, 5'b11111, dsts(5,6,7,5,6), 5'b11111, 5'b11111); expect_grant("bad_dst", 5'b00000);

`ifdef SA_STARVE_GUARD_EN
        // Input 4 blocked 3 cycles, then beats input 0 despite pointer at 0.
        step(1'b1, 5'b00000, '0, 5'b00000, 5'b00000);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 5'b10000, dsts(0,0,0,0,0), 5'b11111, 5'b11110);
            expect_grant("starve_block", 5'b00000);
        end
        step(1'b0, 5'b10001, dsts(0,0,0,0,0), 5'b11111, 5'b11111); expect_grant("starve_win", 5'b10000);
`endif

        // Randomized traffic with occasional reset pulses.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                rd[i*DW +: DW] = DW'($urandom_range(0, 7));
                rr[i]          = ($urandom_range(0, 9) < 8);
            end
            step(($urandom_range(0, 99) == 0), N'($urandom), rd, N'($urandom), rr);
        end

        step(1'b0, 5'b00000, '0, 5'b00000, 5'b11111);
        @(negedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
